rv32i_hazard_ctrl: RTL and testbench
====================================

# rv32i_hazard_ctrl

Parametrised hazard controller for the 5-stage RV32I pipeline, sitting beside the ID stage. It detects load-use hazards against a data memory with configurable load latency and stalls for that many cycles. It also freezes the whole pipeline while data memory is busy and drives flushes on a taken branch/jump resolved in EX. With LOAD_LAT = 1 and no memory-busy or branch events, its stall behaviour is the classic single-cycle load-use bubble, except that x0 never causes a stall.

## Interface
Parameters:
- LOAD_LAT, default 1: cycles from a load in EX until its data is forwardable to ID; legal 1..8.
- CNT_W, default 3: stall-counter width; must satisfy 2^CNT_W > LOAD_LAT-1.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_id, rs2_id  in  5  source registers of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1  the ID instruction actually reads rs1/rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- memread_ex  in  1  the EX instruction is a load.
- branch_taken_ex  in  1  taken branch/jump resolved in EX.
- dmem_busy  in  1  data memory cannot complete this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write, ex_mem_write  out  1  ID/EX and EX/MEM register enables.
- control_stall  out  1  insert bubble (zero controls) into ID/EX.
- flush_if_id  out  1  clear IF/ID to NOP.

## Operation
- hit is true when all of the following hold:
  - memread_ex = 1;
  - rd_ex ≠ 0;
  - (rs1_used_id and rd_ex == rs1_id) or (rs2_used_id and rd_ex == rs2_id).
- FSM states are IDLE and STALL. A down-counter cnt[CNT_W-1:0] tracks the remaining stall cycles.
- Decisions are evaluated in priority order each cycle:
  1. **dmem_busy = 1 (freeze):**
     - pc_write, if_id_write, id_ex_write and ex_mem_write are all 0.
     - control_stall = 0 and flush_if_id = 0.
     - FSM state and cnt hold.
  2. **branch_taken_ex = 1:**
     - flush_if_id = 1 and control_stall = 1.
     - pc_write = 1 and if_id_write = 1.
     - Next state is IDLE and cnt is cleared.
  3. **IDLE with hit:**
     - pc_write = 0, if_id_write = 0, control_stall = 1.
     - If LOAD_LAT > 1: next state is STALL and cnt ← LOAD_LAT-2.
     - If LOAD_LAT = 1: stay in IDLE.
  4. **STALL:**
     - pc_write = 0, if_id_write = 0, control_stall = 1.
     - If cnt == 0: next state is IDLE. Otherwise cnt ← cnt-1.
  5. **Otherwise:** all enables are 1; control_stall = 0 and flush_if_id = 0.
- id_ex_write and ex_mem_write are 1 in every case except freeze.
- Outputs are combinational from the inputs and the registered state. There is no output register.

## Timing
- Reset (rst_n = 0) forces state to IDLE and cnt to 0, asynchronously.
  - With all inputs at 0 during reset, outputs are: pc_write = 1, if_id_write = 1, id_ex_write = 1, ex_mem_write = 1, control_stall = 0, flush_if_id = 0.
- Response latency is 0: a hit stalls in the same cycle.
- Total load-use stall is exactly LOAD_LAT non-frozen cycles: the detect cycle plus LOAD_LAT-1 cycles in STALL.
  - Freeze cycles extend the stall without consuming the count.
- On leaving STALL, the next cycle re-evaluates hit normally. That cycle's EX holds a bubble, so no spurious re-stall occurs.
- Reset asserted mid-stall aborts the stall immediately.
- Simultaneous dmem_busy and branch_taken_ex: freeze wins. The branch flush takes effect in the first non-busy cycle, because EX is held.
- Simultaneous hit and branch_taken_ex is impossible, since both come from the same EX instruction. If it occurs anyway, the branch wins.

## Configuration
- Macro RV32I_HAZARD_PERF_EN.
- **Defined:**
  - Adds output stall_cycles (out, 32 bits).
  - stall_cycles is a saturating counter that increments on every cycle with control_stall = 1 and branch_taken_ex = 0 (load-use stalls only).
  - It resets to 0 and stops at 0xFFFFFFFF.
- **Undefined:** the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Basic load-use:** LOAD_LAT = 1, memread_ex = 1, rd_ex = 5, rs1_id = 5, rs1_used_id = 1 → one cycle with pc_write = 0, if_id_write = 0, control_stall = 1, then all enables are 1.
- **Multi-cycle load-use:** LOAD_LAT = 3, same hit for one cycle, then memread_ex = 0 → control_stall = 1 for exactly 3 consecutive cycles. With RV32I_HAZARD_PERF_EN defined, stall_cycles reads 3.
- **x0 and unused source:**
  - rd_ex = 0 with rs1_id = 0 → no stall.
  - rd_ex = 7, rs2_id = 7, rs2_used_id = 0 → no stall.
- **Freeze during stall:** LOAD_LAT = 3, hit, then dmem_busy = 1 for 2 cycles inside STALL → all four enables are 0 for those 2 cycles, and the stall still totals 3 non-frozen cycles.
- **Branch:** branch_taken_ex = 1 → flush_if_id = 1, control_stall = 1, pc_write = 1 in the same cycle, and the FSM is in IDLE the next cycle.
- **Reset mid-operation:** rst_n driven low during cycle 2 of a LOAD_LAT = 4 stall → outputs return immediately to their reset values; cnt = 0 and state IDLE after release.

Source files
------------

// File: rtl/rv32i_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_hazard_ctrl
//
// Hazard controller for a 5-stage RV32I pipeline, placed beside the ID stage.
// - Load-use hazards: when a load in EX writes a register that the ID
//   instruction reads, the front end is stalled for LOAD_LAT non-frozen
//   cycles. The first of these cycles is the detect cycle. The remaining
//   LOAD_LAT-1 cycles are spent in the STALL state.
// - Data memory busy: the whole pipeline is frozen. The FSM state and the
//   stall counter hold.
// - Taken branch/jump in EX: IF/ID is flushed and a bubble is put into ID/EX.
//
// Parameters
//   LOAD_LAT  cycles from a load in EX until its data is forwardable (1..8)
//   CNT_W     stall-counter width, 2**CNT_W > LOAD_LAT-1
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   rs1_id, rs2_id              source registers of the ID instruction
//   rs1_used_id, rs2_used_id    the ID instruction really reads rs1/rs2
//   rd_ex, memread_ex           destination register of EX, EX is a load
//   branch_taken_ex             taken branch/jump resolved in EX
//   dmem_busy                   data memory cannot complete this cycle
//   pc_write, if_id_write       front-end enables
//   id_ex_write, ex_mem_write   back-end register enables
//   control_stall               zero the controls entering ID/EX
//   flush_if_id                 clear IF/ID to a NOP
//   stall_cycles                saturating count of load-use stall cycles
//                               (only present with RV32I_HAZARD_PERF_EN)
//
// Optional feature macro: RV32I_HAZARD_PERF_EN
// ---------------------------------------------------------------------------
module rv32i_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [4:0] rd_ex,
  input  logic       memread_ex,
  input  logic       branch_taken_ex,
  input  logic       dmem_busy,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       ex_mem_write,
  output logic       control_stall,
  output logic       flush_if_id
`ifdef RV32I_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Value loaded into the counter on a hit. The counter then counts the
  // remaining STALL cycles minus one. With LOAD_LAT = 1 there is no STALL
  // state, so the value is never used.
  localparam logic [CNT_W-1:0] RELOAD = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // A write to x0 never creates a dependency.
  assign hit = memread_ex && (rd_ex != 5'd0) &&
               ((rs1_used_id && (rd_ex == rs1_id)) ||
                (rs2_used_id && (rd_ex == rs2_id)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: freeze, then branch, then load-use stall, then normal flow.
  // A branch and a hit cannot come from the same EX instruction. If both
  // appear anyway, the branch wins.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    control_stall = 1'b0;
    flush_if_id   = 1'b0;

    if (dmem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (branch_taken_ex) begin
      flush_if_id   = 1'b1;
      control_stall = 1'b1;
      state_d       = IDLE;
      cnt_d         = '0;
    end else if (state_q == STALL) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      control_stall = 1'b1;
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (hit) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      control_stall = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = STALL;
        cnt_d   = RELOAD;
      end
    end
  end

`ifdef RV32I_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  // Counts load-use bubbles only. Branch bubbles are excluded, and frozen
  // cycles are excluded because control_stall is low while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (control_stall && !branch_taken_ex && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_hazard_ctrl
//
// Three controllers (LOAD_LAT = 1, 3, 4) share the same stimulus. A
// behavioural model tracks, for each latency, how many load-use stall
// cycles are still owed. Output vectors are packed in the order
// {pc_write, if_id_write, id_ex_write, ex_mem_write, control_stall,
// flush_if_id}.
// ---------------------------------------------------------------------------
module tb_rv32i_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] rs1Id, rs2Id, rdEx;
  logic       rs1UsedId, rs2UsedId, memreadEx, branchTakenEx, dmemBusy;

  logic       pcWrite[3], ifIdWrite[3], idExWrite[3], exMemWrite[3];
  logic       controlStall[3], flushIfId[3];
  logic [5:0] obsVec[3];
`ifdef RV32I_HAZARD_PERF_EN
  logic [31:0] stallCycles[3];
`endif

  int passCount  = 0;
  int checkCount = 0;
  int rem[3];
  longint unsigned perfExp[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv32i_hazard_ctrl #(.LOAD_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4)), .CNT_W(3)) dut (
      .clk             (clk),
      .rst_n           (rstN),
      .rs1_id          (rs1Id),
      .rs2_id          (rs2Id),
      .rs1_used_id     (rs1UsedId),
      .rs2_used_id     (rs2UsedId),
      .rd_ex           (rdEx),
      .memread_ex      (memreadEx),
      .branch_taken_ex (branchTakenEx),
      .dmem_busy       (dmemBusy),
      .pc_write        (pcWrite[g]),
      .if_id_write     (ifIdWrite[g]),
      .id_ex_write     (idExWrite[g]),
      .ex_mem_write    (exMemWrite[g]),
      .control_stall   (controlStall[g]),
      .flush_if_id     (flushIfId[g])
`ifdef RV32I_HAZARD_PERF_EN
      ,
      .stall_cycles    (stallCycles[g])
`endif
    );
    assign obsVec[g] = {pcWrite[g], ifIdWrite[g], idExWrite[g], exMemWrite[g],
                        controlStall[g], flushIfId[g]};
  end

  function automatic int latOf(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic bit modelHit();
    return memreadEx && (rdEx != 5'd0) &&
           ((rs1UsedId && rdEx == rs1Id) || (rs2UsedId && rdEx == rs2Id));
  endfunction

  // Expected outputs for the current inputs and the stall cycles still owed.
  function automatic logic [5:0] expectOut(int i);
    if (dmemBusy)                  return 6'b000000;
    if (branchTakenEx)             return 6'b111111;
    if (rem[i] > 0 || modelHit())  return 6'b001110;
    return 6'b111100;
  endfunction

  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic br, input logic bz);
    rs1Id = r1; rs2Id = r2; rs1UsedId = u1; rs2UsedId = u2;
    rdEx = rd; memreadEx = mr; branchTakenEx = br; dmemBusy = bz;
    #2;
  endtask

  task automatic applyIdle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advances one clock and updates the owed-stall model from the spec rules.
  task automatic advanceClock();
    int nextRem[3];
    for (int i = 0; i < 3; i++) begin
      if (!rstN)                                   nextRem[i] = 0;
      else if (dmemBusy)                           nextRem[i] = rem[i];
      else if (branchTakenEx)                      nextRem[i] = 0;
      else if (rem[i] > 0)                         nextRem[i] = rem[i] - 1;
      else if (modelHit())                         nextRem[i] = latOf(i) - 1;
      else                                         nextRem[i] = 0;
      if (!rstN)
        perfExp[i] = 0;
      else if (!dmemBusy && !branchTakenEx && (rem[i] > 0 || modelHit()) && perfExp[i] < 64'hFFFF_FFFF)
        perfExp[i] = perfExp[i] + 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rem[i] = nextRem[i];
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin rem[i] = 0; perfExp[i] = 0; end
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (obsVec[i] !== 6'b111100)
        $display("[TB] FAIL reset_outputs lat%0d: got %b want %b", latOf(i), obsVec[i], 6'b111100);
      else passCount++;
    end
    advanceClock();
    rstN = 1'b1;
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (obsVec[i] !== 6'b111100)
        $display("[TB] FAIL after_reset lat%0d: got %b want %b", latOf(i), obsVec[i], 6'b111100);
      else passCount++;
    end
    advanceClock();
  endtask

  task automatic test_load_use();
    // One hit cycle followed by idle cycles: stall length equals LOAD_LAT.
    for (int c = 0; c < 6; c++) begin
      if (c == 0) applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      else        applyIdle();
      for (int i = 0; i < 3; i++) begin
        checkCount++;
        if (obsVec[i] !== expectOut(i))
          $display("[TB] FAIL load_use c%0d lat%0d: got %b want %b", c, latOf(i), obsVec[i], expectOut(i));
        else passCount++;
        checkCount++;
        if (controlStall[i] !== (c < latOf(i)))
          $display("[TB] FAIL stall_len c%0d lat%0d: got %0b want %0b", c, latOf(i), controlStall[i], (c < latOf(i)));
        else passCount++;
      end
      advanceClock();
    end
`ifdef RV32I_HAZARD_PERF_EN
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (stallCycles[i] !== 32'(latOf(i)))
        $display("[TB] FAIL perf_count lat%0d: got %0d want %0d", latOf(i), stallCycles[i], latOf(i));
      else passCount++;
    end
`endif
  endtask

  task automatic test_x0_unused();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      else        applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        checkCount++;
        if (obsVec[i] !== 6'b111100)
          $display("[TB] FAIL no_stall c%0d lat%0d: got %b want %b", c, latOf(i), obsVec[i], 6'b111100);
        else passCount++;
      end
      advanceClock();
    end
  endtask

  task automatic test_freeze();
    // hit, busy, busy, then idle: freeze cycles do not consume the stall.
    for (int c = 0; c < 7; c++) begin
      case (c)
        0:       applyStimulus(5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        default: applyIdle();
      endcase
      if (c == 0) applyStimulus(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      if (c == 1 || c == 2) applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        checkCount++;
        if (obsVec[i] !== expectOut(i))
          $display("[TB] FAIL freeze c%0d lat%0d: got %b want %b", c, latOf(i), obsVec[i], expectOut(i));
        else passCount++;
      end
      advanceClock();
    end
  endtask

  task automatic test_branch();
    // hit, branch inside the stall, idle; then busy+branch, branch, idle.
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        1:       applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        3:       applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        4:       applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        default: applyIdle();
      endcase
      for (int i = 0; i < 3; i++) begin
        checkCount++;
        if (obsVec[i] !== expectOut(i))
          $display("[TB] FAIL branch c%0d lat%0d: got %b want %b", c, latOf(i), obsVec[i], expectOut(i));
        else passCount++;
      end
      advanceClock();
    end
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    advanceClock();
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (obsVec[i] !== expectOut(i))
        $display("[TB] FAIL pre_reset lat%0d: got %b want %b", latOf(i), obsVec[i], expectOut(i));
      else passCount++;
    end
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin rem[i] = 0; perfExp[i] = 0; end
    #1;
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (obsVec[i] !== 6'b111100)
        $display("[TB] FAIL reset_abort lat%0d: got %b want %b", latOf(i), obsVec[i], 6'b111100);
      else passCount++;
    end
    advanceClock();
    rstN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      applyIdle();
      for (int i = 0; i < 3; i++) begin
        checkCount++;
        if (obsVec[i] !== 6'b111100)
          $display("[TB] FAIL post_reset c%0d lat%0d: got %b want %b", c, latOf(i), obsVec[i], 6'b111100);
        else passCount++;
      end
      advanceClock();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      for (int i = 0; i < 3; i++) begin
        checkCount++;
        if (obsVec[i] !== expectOut(i))
          $display("[TB] FAIL random c%0d lat%0d: got %b want %b", c, latOf(i), obsVec[i], expectOut(i));
        else passCount++;
      end
      advanceClock();
    end
`ifdef RV32I_HAZARD_PERF_EN
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (stallCycles[i] !== 32'(perfExp[i]))
        $display("[TB] FAIL perf_random lat%0d: got %0d want %0d", latOf(i), stallCycles[i], perfExp[i]);
      else passCount++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_unused();
    test_freeze();
    test_branch();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
